// File: rtl/l2cache_writeback_buffer_pkg.sv
// Shared L2 definitions: drain FSM encoding, line offset width, line width macro.
// The optional query forwarding port is enabled by WBUF_FORWARD_EN.
`ifndef L2_LINE_W
`define L2_LINE_W(wn) (32*(wn))
`endif

package l2cache_writeback_buffer_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } wb_state_e;

    function automatic int line_off_w(input int word_num);
        return $clog2(word_num * 4);
    endfunction

endpackage

// File: rtl/l2cache_wbuf_fifo.sv
// Dirty victim storage: pointers, occupancy and per-entry address comparators.
// WBUF_FORWARD_EN adds the youngest-match line output.
module l2cache_wbuf_fifo
    import l2cache_writeback_buffer_pkg::*;
#(
    parameter int addr_width = 32,
    parameter int word_num   = 16,
    parameter int depth_log  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic [addr_width-1:0]          push_addr_i,
    input  logic [`L2_LINE_W(word_num)-1:0] push_data_i,
    input  logic                           pop_i,
    output logic [addr_width-1:0]          head_addr_o,
    output logic [`L2_LINE_W(word_num)-1:0] head_data_o,
    output logic [depth_log:0]             count_o,
    output logic                           full_o,
    input  logic [addr_width-1:0]          query_addr_i,
    output logic                           query_hit_o
`ifdef WBUF_FORWARD_EN
    ,
    output logic [`L2_LINE_W(word_num)-1:0] query_data_o
`endif
);

    localparam int DEPTH = 1 << depth_log;
    localparam int OFF_W = line_off_w(word_num);
    localparam int LW    = `L2_LINE_W(word_num);

    logic [addr_width-1:0] addr_q [DEPTH];
    logic [LW-1:0]         data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [depth_log-1:0]  wr_ptr_q;
    logic [depth_log-1:0]  rd_ptr_q;
    logic [depth_log:0]    count_q;
    logic [depth_log:0]    count_d;
    logic [DEPTH-1:0]      match;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_i) begin
                wr_ptr_q          <= wr_ptr_q + 1'b1;
                valid_q[wr_ptr_q] <= 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q          <= rd_ptr_q + 1'b1;
                valid_q[rd_ptr_q] <= 1'b0;
            end
        end
    end

    // Line storage needs no reset; valid_q gates every read.
    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign count_o     = count_q;
    assign full_o      = (count_q == (depth_log+1)'(DEPTH));

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid_q[i] &&
                (((addr_q[i] ^ query_addr_i) >> OFF_W) == '0);
        end
    end

    assign query_hit_o = |match;

`ifdef WBUF_FORWARD_EN
    // Walk oldest to youngest so the last match wins.
    always_comb begin
        logic [depth_log-1:0] idx;
        idx          = '0;
        query_data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + depth_log'(k);
            if (match[idx]) begin
                query_data_o = data_q[idx];
            end
        end
    end
`endif

endmodule

// File: rtl/l2cache_writeback_buffer.sv
// L2 write-back buffer: queues dirty victims and drains them as write bursts.
// WBUF_FORWARD_EN adds wbuf_query_data so misses can refill from the buffer.
module l2cache_writeback_buffer
    import l2cache_writeback_buffer_pkg::*;
#(
    parameter int addr_width = 32,
    parameter int word_num   = 16,
    parameter int depth_log  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wbuf_push_valid,
    output logic                           wbuf_push_ready,
    input  logic                           wbuf_push_dirty,
    input  logic [addr_width-1:0]          wbuf_push_addr,
    input  logic [`L2_LINE_W(word_num)-1:0] wbuf_push_data,
    input  logic [addr_width-1:0]          wbuf_query_addr,
    output logic                           wbuf_query_hit,
    output logic                           mem_wr_req,
    output logic [addr_width-1:0]          mem_wr_addr,
    input  logic                           mem_wr_addr_ready,
    output logic                           mem_wr_valid,
    output logic [31:0]                    mem_wr_data,
    output logic                           mem_wr_last,
    input  logic                           mem_wr_data_ready,
    input  logic                           mem_wr_done,
    output logic                           wbuf_empty,
    output logic [depth_log:0]             wbuf_count
`ifdef WBUF_FORWARD_EN
    ,
    output logic [`L2_LINE_W(word_num)-1:0] wbuf_query_data
`endif
);

    localparam int LW = `L2_LINE_W(word_num);
    localparam int BW = (word_num > 1) ? $clog2(word_num) : 1;

    wb_state_e             state_q;
    wb_state_e             state_d;
    logic [BW-1:0]         beat_q;
    logic [BW-1:0]         beat_d;
    logic [addr_width-1:0] baddr_q;
    logic [LW-1:0]         bdata_q;
    logic                  latch;
    logic                  pop;
    logic                  push_en;
    logic                  full;
    logic [addr_width-1:0] head_addr;
    logic [LW-1:0]         head_data;
    logic [depth_log:0]    count;

    // Clean victims are acknowledged even when full; only dirty ones stall.
    assign wbuf_push_ready = !full || !wbuf_push_dirty;
    assign push_en = wbuf_push_valid && wbuf_push_dirty && !full;

    l2cache_wbuf_fifo #(
        .addr_width (addr_width),
        .word_num   (word_num),
        .depth_log  (depth_log)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push_en),
        .push_addr_i  (wbuf_push_addr),
        .push_data_i  (wbuf_push_data),
        .pop_i        (pop),
        .head_addr_o  (head_addr),
        .head_data_o  (head_data),
        .count_o      (count),
        .full_o       (full),
        .query_addr_i (wbuf_query_addr),
        .query_hit_o  (wbuf_query_hit)
`ifdef WBUF_FORWARD_EN
        ,
        .query_data_o (wbuf_query_data)
`endif
    );

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        latch        = 1'b0;
        pop          = 1'b0;
        mem_wr_req   = 1'b0;
        mem_wr_valid = 1'b0;
        mem_wr_last  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (count != '0) begin
                    latch   = 1'b1;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                mem_wr_req = 1'b1;
                if (mem_wr_addr_ready) begin
                    beat_d  = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                mem_wr_valid = 1'b1;
                mem_wr_last  = (beat_q == BW'(word_num - 1));
                if (mem_wr_data_ready) begin
                    if (mem_wr_last) begin
                        state_d = ST_RESP;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (mem_wr_done) begin
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            baddr_q <= '0;
            bdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (latch) begin
                baddr_q <= head_addr;
                bdata_q <= head_data;
            end
        end
    end

    assign mem_wr_addr = baddr_q;
    assign mem_wr_data = bdata_q[{beat_q, 5'b0} +: 32];
    assign wbuf_empty  = (count == '0) && (state_q == ST_IDLE);
    assign wbuf_count  = count;

endmodule

// File: tb/tb_l2cache_writeback_buffer.sv
// Bench for l2cache_writeback_buffer: vector table, hand sequences, random run.
// Expected behaviour comes from a queue-of-lines model fed by observed handshakes.
module tb_l2cache_writeback_buffer;

    localparam int AW = 32;
    localparam int WN = 16;
    localparam int DL = 2;
    localparam int LW = 32 * WN;

    logic          clk = 1'b0;
    logic          rst;
    logic          wbuf_push_valid;
    logic          wbuf_push_ready;
    logic          wbuf_push_dirty;
    logic [AW-1:0] wbuf_push_addr;
    logic [LW-1:0] wbuf_push_data;
    logic [AW-1:0] wbuf_query_addr;
    logic          wbuf_query_hit;
    logic          mem_wr_req;
    logic [AW-1:0] mem_wr_addr;
    logic          mem_wr_addr_ready;
    logic          mem_wr_valid;
    logic [31:0]   mem_wr_data;
    logic          mem_wr_last;
    logic          mem_wr_data_ready;
    logic          mem_wr_done;
    logic          wbuf_empty;
    logic [DL:0]   wbuf_count;
`ifdef WBUF_FORWARD_EN
    logic [LW-1:0] wbuf_query_data;
`endif

    always #5 clk = ~clk;

    l2cache_writeback_buffer #(
        .addr_width (AW),
        .word_num   (WN),
        .depth_log  (DL)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .wbuf_push_valid   (wbuf_push_valid),
        .wbuf_push_ready   (wbuf_push_ready),
        .wbuf_push_dirty   (wbuf_push_dirty),
        .wbuf_push_addr    (wbuf_push_addr),
        .wbuf_push_data    (wbuf_push_data),
        .wbuf_query_addr   (wbuf_query_addr),
        .wbuf_query_hit    (wbuf_query_hit),
        .mem_wr_req        (mem_wr_req),
        .mem_wr_addr       (mem_wr_addr),
        .mem_wr_addr_ready (mem_wr_addr_ready),
        .mem_wr_valid      (mem_wr_valid),
        .mem_wr_data       (mem_wr_data),
        .mem_wr_last       (mem_wr_last),
        .mem_wr_data_ready (mem_wr_data_ready),
        .mem_wr_done       (mem_wr_done),
        .wbuf_empty        (wbuf_empty),
        .wbuf_count        (wbuf_count)
`ifdef WBUF_FORWARD_EN
        ,
        .wbuf_query_data   (wbuf_query_data)
`endif
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [LW-1:0] d;
    } line_t;

    typedef struct {
        bit            v;
        bit            d;
        logic [AW-1:0] a;
        logic [AW-1:0] qa;
        bit            rdy;
        bit            hit;
        int            cnt;
    } vec_t;

    line_t         q[$];
    int            total = 0;
    int            bad = 0;
    bit            hold_addr = 0;
    bit            rnd = 0;
    bit            auto_done = 1;
    bit            pending = 0;
    int            beat = 0;
    int            bursts = 0;
    int            accepted = 0;
    bit            a_stall = 0;
    bit            d_stall = 0;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_data;
    logic          s_last;
    logic [LW-1:0] hd;

    task automatic chk(input string nm, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit m_hit(input logic [AW-1:0] qa);
        foreach (q[i]) begin
            if (q[i].a[AW-1:6] == qa[AW-1:6]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [LW-1:0] m_fwd(input logic [AW-1:0] qa);
        logic [LW-1:0] r;
        r = '0;
        foreach (q[i]) begin
            if (q[i].a[AW-1:6] == qa[AW-1:6]) r = q[i].d;
        end
        return r;
    endfunction

    // Memory-side responder: readies and the completion pulse.
    always @(posedge clk) begin
        #1;
        mem_wr_addr_ready = !hold_addr && (!rnd || $urandom_range(0, 2) != 0);
        mem_wr_data_ready = !rnd || ($urandom_range(0, 3) != 0);
        if (rst || mem_wr_done) begin
            mem_wr_done = 1'b0;
        end else if (pending && auto_done && (!rnd || $urandom_range(0, 1) == 0)) begin
            mem_wr_done = 1'b1;
        end else if (rnd && !pending && $urandom_range(0, 7) == 0) begin
            mem_wr_done = 1'b1;
        end
    end

    // Model update and per-cycle checks, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            a_stall = 0;
            d_stall = 0;
        end else begin
            if (a_stall) begin
                chk("addr_hold_req", mem_wr_req, 1);
                chk("addr_hold", mem_wr_addr, s_addr);
            end
            if (d_stall) begin
                chk("data_hold_valid", mem_wr_valid, 1);
                chk("data_hold", mem_wr_data, s_data);
                chk("last_hold", mem_wr_last, s_last);
            end
            chk("count", wbuf_count, q.size());
            chk("empty", wbuf_empty, q.size() == 0);
            chk("push_ready", wbuf_push_ready, (q.size() < 4) || !wbuf_push_dirty);
            chk("query_hit", wbuf_query_hit, m_hit(wbuf_query_addr));
            if (q.size() == 0) begin
                chk("idle_req", mem_wr_req, 0);
                chk("idle_valid", mem_wr_valid, 0);
            end
`ifdef WBUF_FORWARD_EN
            if (m_hit(wbuf_query_addr))
                chk("fwd_data", wbuf_query_data, m_fwd(wbuf_query_addr));
`endif
            a_stall = mem_wr_req && !mem_wr_addr_ready;
            s_addr  = mem_wr_addr;
            d_stall = mem_wr_valid && !mem_wr_data_ready;
            s_data  = mem_wr_data;
            s_last  = mem_wr_last;
            if (mem_wr_done && pending) begin
                pending = 0;
                bursts++;
                void'(q.pop_front());
            end
            if (mem_wr_req && mem_wr_addr_ready) begin
                chk("burst_has_entry", q.size() != 0, 1);
                if (q.size() != 0) chk("burst_addr", mem_wr_addr, q[0].a);
                beat = 0;
            end
            if (mem_wr_valid && mem_wr_data_ready) begin
                chk("beat_has_entry", q.size() != 0, 1);
                if (q.size() != 0) begin
                    hd = q[0].d;
                    chk("beat_data", mem_wr_data, hd[beat*32 +: 32]);
                end
                chk("beat_last", mem_wr_last, beat == WN - 1);
                if (mem_wr_last) pending = 1;
                beat++;
            end
            if (wbuf_push_valid && wbuf_push_ready && wbuf_push_dirty) begin
                q.push_back('{wbuf_push_addr, wbuf_push_data});
                accepted++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input bit d, input logic [AW-1:0] a, input logic [LW-1:0] dat);
        wbuf_push_valid = 1'b1;
        wbuf_push_dirty = d;
        wbuf_push_addr  = a;
        wbuf_push_data  = dat;
        step();
        wbuf_push_valid = 1'b0;
        wbuf_push_dirty = 1'b0;
    endtask

    task automatic wait_drain(input int maxc);
        int n;
        n = 0;
        while ((q.size() != 0 || !wbuf_empty) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_in_time", n < maxc, 1);
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int w = 0; w < WN; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t          tv[7];
        logic [LW-1:0] ln;
        int            n;

        rst = 1'b1;
        wbuf_push_valid = 0;
        wbuf_push_dirty = 0;
        wbuf_push_addr  = '0;
        wbuf_push_data  = '0;
        wbuf_query_addr = '0;
        mem_wr_done     = 0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_req", mem_wr_req, 0);
        chk("rst_valid", mem_wr_valid, 0);
        chk("rst_last", mem_wr_last, 0);
        chk("rst_addr", mem_wr_addr, 0);
        chk("rst_count", wbuf_count, 0);
        chk("rst_empty", wbuf_empty, 1);
        chk("rst_ready", wbuf_push_ready, 1);
        chk("rst_hit", wbuf_query_hit, 0);
        step();
        rst = 1'b0;
        step();

        for (int w = 0; w < WN; w++) ln[w*32 +: 32] = 32'hA0 + w;
        push(1, 32'h1000, ln);
        wait_drain(100);
        chk("t1_bursts", bursts, 1);
        chk("t1_count", wbuf_count, 0);

        wbuf_push_valid = 1;
        wbuf_push_dirty = 0;
        wbuf_push_addr  = 32'h2000;
        #1;
        chk("clean_ready", wbuf_push_ready, 1);
        step();
        wbuf_push_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("clean_no_req", mem_wr_req, 0);
            chk("clean_count", wbuf_count, 0);
            step();
        end

        tv[0] = '{1, 1, 32'h3000, 32'h3004, 1, 0, 0};
        tv[1] = '{1, 1, 32'h5000, 32'h3004, 1, 1, 1};
        tv[2] = '{1, 1, 32'h6000, 32'h3040, 1, 0, 2};
        tv[3] = '{1, 1, 32'h7000, 32'h5008, 1, 1, 3};
        tv[4] = '{1, 1, 32'h8000, 32'h7000, 0, 1, 4};
        tv[5] = '{1, 0, 32'h9000, 32'h8000, 1, 0, 4};
        tv[6] = '{0, 1, 32'hA000, 32'h303C, 0, 1, 4};
        hold_addr = 1;
        step();
        foreach (tv[i]) begin
            wbuf_push_valid = tv[i].v;
            wbuf_push_dirty = tv[i].d;
            wbuf_push_addr  = tv[i].a;
            wbuf_push_data  = rand_line();
            wbuf_query_addr = tv[i].qa;
            #1;
            chk($sformatf("tv%0d_ready", i), wbuf_push_ready, tv[i].rdy);
            chk($sformatf("tv%0d_hit", i), wbuf_query_hit, tv[i].hit);
            chk($sformatf("tv%0d_count", i), wbuf_count, tv[i].cnt);
            step();
        end
        wbuf_push_valid = 0;
        wbuf_push_dirty = 0;
        hold_addr = 0;
        wait_drain(500);
        chk("t3_bursts", bursts, 5);

        auto_done = 0;
        wbuf_query_addr = 32'h3004;
        push(1, 32'h3000, rand_line());
        n = 0;
        while (!pending && n < 100) begin
            step();
            n++;
        end
        chk("t4_reach_resp", pending, 1);
        #1;
        chk("resp_hit_a", wbuf_query_hit, 1);
        step();
        #1;
        chk("resp_hit_b", wbuf_query_hit, 1);
        auto_done = 1;
        step();
        #1;
        chk("done_cycle_hit", wbuf_query_hit, 1);
        step();
        #1;
        chk("after_done_hit", wbuf_query_hit, 0);
        chk("after_done_count", wbuf_count, 0);
        wait_drain(20);

        rnd = 1;
        for (int c = 0; c < 400; c++) begin
            wbuf_push_valid = ($urandom_range(0, 2) == 0);
            wbuf_push_dirty = ($urandom_range(0, 3) != 0);
            wbuf_push_addr  = 32'h10000 + ($urandom_range(0, 5) << 6);
            wbuf_push_data  = rand_line();
            wbuf_query_addr = 32'h10000 + $urandom_range(0, 511);
            step();
        end
        wbuf_push_valid = 0;
        wbuf_push_dirty = 0;
        rnd = 0;
        wait_drain(3000);
        chk("rand_bursts", bursts, accepted);

`ifdef WBUF_FORWARD_EN
        hold_addr = 1;
        step();
        push(1, 32'h4000, {16{32'h11}});
        push(1, 32'h4000, {16{32'h22}});
        wbuf_query_addr = 32'h4010;
        #1;
        chk("fwd_youngest", wbuf_query_data, {16{32'h22}});
        hold_addr = 0;
        wait_drain(200);
`endif

        push(1, 32'h5000, rand_line());
        n = 0;
        while (!mem_wr_valid && n < 50) begin
            step();
            n++;
        end
        chk("t7_burst_started", n < 50, 1);
        rst = 1;
        wbuf_push_dirty = 1;
        #1;
        chk("midrst_req", mem_wr_req, 0);
        chk("midrst_valid", mem_wr_valid, 0);
        chk("midrst_count", wbuf_count, 0);
        chk("midrst_empty", wbuf_empty, 1);
        chk("midrst_ready", wbuf_push_ready, 1);
        q.delete();
        pending = 0;
        beat = 0;
        wbuf_push_dirty = 0;
        step();
        step();
        rst = 0;
        step();
        n = bursts;
        push(1, 32'h6000, rand_line());
        wait_drain(100);
        chk("post_rst_burst", bursts, n + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
